// File: rtl/xadc_drp_sequencer.sv
// Reads the four XADC auxiliary channels over the DRP, one sweep per end-of-conversion.
// Keeps a single read outstanding and latches each 12-bit result into its own register.
module xadc_drp_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  input  logic [3:0]  chan_en,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [11:0] res0,
  output logic [11:0] res1,
  output logic [11:0] res2,
  output logic [11:0] res3,
  output logic        sample_valid,
  output logic [1:0]  sample_chan,
  output logic        sweep_done,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StNext} state_e;

  state_e           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       sel_q, sel_d;
  logic             pend_q, pend_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [6:0]       daddr_q, daddr_d;
  logic [3:0][11:0] res_q, res_d;
  logic             sv_q, sv_d;
  logic [1:0]       sc_q, sc_d;
  logic             to_q, to_d;

  logic [2:0] first_en;
  logic [2:0] next_sel;
  logic       trigger;

  function automatic logic [6:0] chan_addr(input logic [1:0] c);
    unique case (c)
      2'd0:    chan_addr = 7'h16;
      2'd1:    chan_addr = 7'h17;
      2'd2:    chan_addr = 7'h1E;
      default: chan_addr = 7'h1F;
    endcase
  endfunction

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [2:0] first_from(input logic [3:0] m, input int from);
    first_from = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= from) first_from = {1'b1, 2'(i)};
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    daddr_d     = daddr_q;
    res_d       = res_q;
    sv_d        = 1'b0;
    sc_d        = sc_q;
    to_d        = to_q;
    den_out     = 1'b0;
    sweep_done  = 1'b0;
    first_en    = first_from(chan_en, 0);
    next_sel    = first_from(mask_q, int'(sel_q) + 1);
    trigger     = pend_q || eoc_in;

    if (eoc_in && state_q != StIdle) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (eoc_in && first_en[2]) begin
          mask_d  = chan_en;
          sel_d   = first_en[1:0];
          daddr_d = chan_addr(first_en[1:0]);
          state_d = StReq;
        end
      end
      StReq: begin
        den_out = 1'b1;
        cnt_d   = CntW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (drdy_in) begin
          res_d[sel_q] = do_in[15:4];
          sv_d         = 1'b1;
          sc_d         = sel_q;
          state_d      = StNext;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = StNext;
        end else begin
          cnt_d = CntW'(cnt_q + 1'b1);
        end
      end
      StNext: begin
        if (next_sel[2]) begin
          sel_d   = next_sel[1:0];
          daddr_d = chan_addr(next_sel[1:0]);
          state_d = StReq;
        end else begin
          sweep_done = 1'b1;
          pend_d     = 1'b0;
          // A trigger seen during the sweep (or right now) starts the next one back-to-back.
          if (trigger && first_en[2]) begin
            mask_d  = chan_en;
            sel_d   = first_en[1:0];
            daddr_d = chan_addr(first_en[1:0]);
            state_d = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      daddr_q <= 7'h16;
      res_q   <= '0;
      sv_q    <= 1'b0;
      sc_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      daddr_q <= daddr_d;
      res_q   <= res_d;
      sv_q    <= sv_d;
      sc_q    <= sc_d;
      to_q    <= to_d;
    end
  end

  assign dwe_out      = 1'b0;
  assign daddr_out    = daddr_q;
  assign res0         = res_q[0];
  assign res1         = res_q[1];
  assign res2         = res_q[2];
  assign res3         = res_q[3];
  assign sample_valid = sv_q;
  assign sample_chan  = sc_q;
  assign timeout_err  = to_q;

endmodule

// File: doc/xadc_drp_sequencer.md
# xadc_drp_sequencer

Sequences reads of the XADC dynamic reconfiguration port (DRP) across the four auxiliary analog channels (VAUX6, VAUX7, VAUX14, VAUX15). Each XADC end-of-conversion pulse starts a sweep. A sweep issues one DRP read per enabled channel in fixed round-robin order and latches each 12-bit result into a per-channel register. The block sits between `xadc_wiz_0` and the display/LED logic, and replaces hard-wired `daddr_in` / `den_in = eoc_out` tie-offs.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles to wait for `drdy_in` after `den_out` before abandoning a read.

Ports:
- `clk`  in  1  system clock, also drives XADC `dclk_in`.
- `rst`  in  1  asynchronous, active-high reset.
- `eoc_in`  in  1  XADC `eoc_out`, a one-cycle pulse.
- `drdy_in`  in  1  XADC `drdy_out`.
- `do_in`  in  16  XADC `do_out`; the result is `do_in[15:4]`.
- `chan_en`  in  4  channel enable mask: bit0 = VAUX6, bit1 = VAUX7, bit2 = VAUX14, bit3 = VAUX15.
- `den_out`  out  1  DRP enable, a one-cycle pulse per read.
- `dwe_out`  out  1  DRP write enable, constant 0.
- `daddr_out`  out  7  DRP address.
- `res0`, `res1`, `res2`, `res3`  out  12 each  latest result for VAUX6, VAUX7, VAUX14 and VAUX15.
- `sample_valid`  out  1  one-cycle pulse when a result register updates.
- `sample_chan`  out  2  index of the register updated with `sample_valid`.
- `sweep_done`  out  1  one-cycle pulse at the end of a sweep.
- `timeout_err`  out  1  sticky flag; set when any read times out, cleared only by `rst`.

## Operation
- DRP addresses: VAUX6 = 7'h16, VAUX7 = 7'h17, VAUX14 = 7'h1E, VAUX15 = 7'h1F.
- States:
  - IDLE: waits for `eoc_in`.
  - REQ: drives `den_out` = 1 for one cycle.
  - WAIT: counts cycles until `drdy_in` or timeout.
  - NEXT: selects the next enabled channel, or ends the sweep.
- Sweep start:
  - In IDLE, `eoc_in` = 1 with `chan_en` != 0: latch `chan_en` into an internal mask, select the lowest set bit, go to REQ.
  - In IDLE, `eoc_in` = 1 with `chan_en` = 0: ignored, stay in IDLE.
- REQ:
  - `den_out` = 1 and `daddr_out` = address of the selected channel.
  - Always goes to WAIT next cycle.
  - `daddr_out` holds its value until the next REQ.
- WAIT:
  - `drdy_in` = 1: `res[sel] <= do_in[15:4]`, `sample_chan <= sel`, `sample_valid` pulses, go to NEXT.
  - Wait counter reaches `TIMEOUT` without `drdy_in`: set `timeout_err`, leave `res[sel]` unchanged, no `sample_valid`, go to NEXT.
- NEXT:
  - If a higher-indexed bit of the latched mask is set, select it and go to REQ.
  - Otherwise pulse `sweep_done` and go to IDLE, or straight to REQ on the lowest set bit if a pending trigger exists.
- Pending trigger:
  - `eoc_in` arriving outside IDLE sets a one-deep pending flag; further pulses are dropped.
  - The flag clears when the new sweep starts.
- `chan_en` changes mid-sweep have no effect until the next sweep start.
- `drdy_in` outside WAIT is ignored.
- `dwe_out` is constantly 0.

## Timing
- Reset values: IDLE state; `den_out` = 0; `daddr_out` = 7'h16; `res0`–`res3` = 0; `sample_valid` = 0; `sample_chan` = 0; `sweep_done` = 0; `timeout_err` = 0; pending flag = 0; wait counter = 0.
- Reset asserted mid-sweep returns to IDLE immediately. No `sweep_done` is emitted and the pending trigger is lost.
- `eoc_in` sampled high at edge N in IDLE gives `den_out` = 1 in cycle N+1.
- `drdy_in` sampled high at edge K in WAIT gives `res*`, `sample_valid` and `sample_chan` in cycle K+1 (NEXT). The next `den_out` is in cycle K+2.
- Timeout:
  - The wait counter starts at 1 in the first WAIT cycle.
  - Timeout fires at the edge where the counter equals `TIMEOUT` and `drdy_in` = 0.
  - `drdy_in` = 1 on that same edge wins over the timeout.
- Per-channel cost with DRP latency L (`den_out` to `drdy_in`) is L+2 cycles.
- `sweep_done` is asserted in the NEXT cycle of the last channel.
- Only one DRP transaction is ever outstanding.

## Test plan
- Reset, then `chan_en` = 4'b0001, `eoc_in` pulse, model returns `do_in` = 16'hABC0 after 3 cycles:
  - `den_out` one cycle after `eoc_in`, with `daddr_out` = 7'h16.
  - `res0` = 12'hABC, `sample_chan` = 0, `sweep_done` in the same cycle as `sample_valid`.
- `chan_en` = 4'b1111 with distinct `do_in` per address:
  - Addresses issued in order 16, 17, 1E, 1F.
  - `res0`–`res3` match their addresses; exactly 4 `sample_valid` pulses, then 1 `sweep_done`.
- `chan_en` = 4'b1010, second `eoc_in` during WAIT of VAUX7, third `eoc_in` also mid-sweep:
  - Sweep reads VAUX7 then VAUX15.
  - Exactly one follow-on sweep, whose first `den_out` is 2 cycles after `drdy_in` of VAUX15.
- `chan_en` = 4'b0011, VAUX6 never answers, `TIMEOUT` = 8:
  - `timeout_err` = 1, `res0` unchanged.
  - VAUX7 `den_out` occurs 10 cycles after the VAUX6 `den_out`; VAUX7 result captured normally.
- `rst` asserted during WAIT:
  - All outputs return to reset values asynchronously.
  - A later `eoc_in` starts a clean sweep.
- `chan_en` = 0 with `eoc_in` pulses: no `den_out` and no `sweep_done` ever.
